// File: rtl/safety_boot_sequencer.sv
// Boot sequencer for the safety island: writes the boot address, raises
// fetch-enable, then polls core-status until end-of-computation, a bus error
// or a timeout. Single-beat AXI master; fixed burst attributes are tied off
// by the parent.
module safety_boot_sequencer #(
  parameter int unsigned          AddrWidth      = 32,
  parameter int unsigned          DataWidth      = 64,
  parameter logic [AddrWidth-1:0] BootAddrAddr   = 32'h0020_0000,
  parameter logic [AddrWidth-1:0] FetchEnAddr    = 32'h0020_0004,
  parameter logic [AddrWidth-1:0] CoreStatusAddr = 32'h0020_0008,
  parameter int unsigned          PollInterval   = 16,
  parameter int unsigned          TimeoutCycles  = 2**20
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  input  logic [31:0]            boot_addr_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   error_o,
  output logic [1:0]             err_code_o,
  output logic [30:0]            exit_code_o,
  output logic                   aw_valid_o,
  input  logic                   aw_ready_i,
  output logic [AddrWidth-1:0]   aw_addr_o,
  output logic                   w_valid_o,
  input  logic                   w_ready_i,
  output logic [DataWidth-1:0]   w_data_o,
  output logic [DataWidth/8-1:0] w_strb_o,
  input  logic                   b_valid_i,
  output logic                   b_ready_o,
  input  logic [1:0]             b_resp_i,
  output logic                   ar_valid_o,
  input  logic                   ar_ready_i,
  output logic [AddrWidth-1:0]   ar_addr_o,
  input  logic                   r_valid_i,
  output logic                   r_ready_o,
  input  logic [DataWidth-1:0]   r_data_i,
  input  logic [1:0]             r_resp_i
);

  localparam int unsigned CntW = $clog2(TimeoutCycles + 1);
  localparam int unsigned GapW = (PollInterval > 1) ? $clog2(PollInterval) : 1;

  localparam logic [1:0] ErrWrResp  = 2'b01;
  localparam logic [1:0] ErrRdResp  = 2'b10;
  localparam logic [1:0] ErrTimeout = 2'b11;

  typedef enum logic [3:0] {
    StIdle, StWrBoot, StWrFetch, StWaitB, StPollAr, StWaitR, StPollGap, StDone, StError
  } state_e;

  state_e          state_q, state_d;
  logic            aw_valid_q, aw_valid_d;
  logic            w_valid_q, w_valid_d;
  logic            wr_fetch_q, wr_fetch_d;
  logic            ar_issued_q, ar_issued_d;
  logic [31:0]     boot_addr_q, boot_addr_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [GapW-1:0] gap_q, gap_d;
  logic            done_q, done_d;
  logic            error_q, error_d;
  logic [1:0]      err_code_q, err_code_d;
  logic [30:0]     exit_code_q, exit_code_d;

  logic                 busy;
  logic                 timeout_hit;
  logic [31:0]          status;
  logic [AddrWidth-1:0] wr_addr;
  logic [31:0]          wr_word;

  assign busy        = !(state_q inside {StIdle, StDone, StError});
  assign timeout_hit = (cnt_q == CntW'(TimeoutCycles));
  assign status      = CoreStatusAddr[2] ? r_data_i[63:32] : r_data_i[31:0];

  // Next-state, handshake tracking and the combinational channel controls.
  always_comb begin
    state_d     = state_q;
    aw_valid_d  = aw_valid_q;
    w_valid_d   = w_valid_q;
    wr_fetch_d  = wr_fetch_q;
    ar_issued_d = ar_issued_q;
    boot_addr_d = boot_addr_q;
    cnt_d       = cnt_q;
    gap_d       = gap_q;
    done_d      = done_q;
    error_d     = error_q;
    err_code_d  = err_code_q;
    exit_code_d = exit_code_q;
    b_ready_o   = 1'b0;
    ar_valid_o  = 1'b0;
    r_ready_o   = 1'b0;

    // Saturates so the timeout stays visible until it is acted on.
    if (busy && !timeout_hit) cnt_d = cnt_q + CntW'(1);

    unique case (state_q)
      StIdle, StDone, StError: begin
        if (start_i) begin
          state_d     = StWrBoot;
          boot_addr_d = boot_addr_i;
          aw_valid_d  = 1'b1;
          w_valid_d   = 1'b1;
          wr_fetch_d  = 1'b0;
          cnt_d       = '0;
          done_d      = 1'b0;
          error_d     = 1'b0;
          err_code_d  = '0;
          exit_code_d = '0;
        end
      end
      StWrBoot, StWrFetch: begin
        aw_valid_d = aw_valid_q & ~aw_ready_i;
        w_valid_d  = w_valid_q & ~w_ready_i;
        if (!aw_valid_d && !w_valid_d) state_d = StWaitB;
      end
      StWaitB: begin
        b_ready_o = 1'b1;
        if (b_valid_i) begin
          if (b_resp_i != 2'b00) begin
            state_d    = StError;
            error_d    = 1'b1;
            err_code_d = ErrWrResp;
          end else if (!wr_fetch_q) begin
            state_d    = StWrFetch;
            aw_valid_d = 1'b1;
            w_valid_d  = 1'b1;
            wr_fetch_d = 1'b1;
          end else begin
            state_d = StPollAr;
          end
        end
      end
      StPollAr: begin
        // Timeout may only cancel a read that has not yet been presented.
        if (timeout_hit && !ar_issued_q) begin
          state_d    = StError;
          error_d    = 1'b1;
          err_code_d = ErrTimeout;
        end else begin
          ar_valid_o = 1'b1;
          if (ar_ready_i) begin
            state_d     = StWaitR;
            ar_issued_d = 1'b0;
          end else begin
            ar_issued_d = 1'b1;
          end
        end
      end
      StWaitR: begin
        r_ready_o = 1'b1;
        if (r_valid_i) begin
          if (r_resp_i != 2'b00) begin
            state_d    = StError;
            error_d    = 1'b1;
            err_code_d = ErrRdResp;
          end else if (status[31]) begin
            state_d     = StDone;
            done_d      = 1'b1;
            exit_code_d = status[30:0];
          end else begin
            state_d = StPollGap;
            gap_d   = GapW'(PollInterval - 1);
          end
        end
      end
      StPollGap: begin
        if (timeout_hit) begin
          state_d    = StError;
          error_d    = 1'b1;
          err_code_d = ErrTimeout;
        end else if (gap_q == '0) begin
          state_d = StPollAr;
        end else begin
          gap_d = gap_q - GapW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      aw_valid_q  <= 1'b0;
      w_valid_q   <= 1'b0;
      wr_fetch_q  <= 1'b0;
      ar_issued_q <= 1'b0;
      boot_addr_q <= '0;
      cnt_q       <= '0;
      gap_q       <= '0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      err_code_q  <= '0;
      exit_code_q <= '0;
    end else begin
      state_q     <= state_d;
      aw_valid_q  <= aw_valid_d;
      w_valid_q   <= w_valid_d;
      wr_fetch_q  <= wr_fetch_d;
      ar_issued_q <= ar_issued_d;
      boot_addr_q <= boot_addr_d;
      cnt_q       <= cnt_d;
      gap_q       <= gap_d;
      done_q      <= done_d;
      error_q     <= error_d;
      err_code_q  <= err_code_d;
      exit_code_q <= exit_code_d;
    end
  end

  // Payloads are zeroed while their valid is low so every output reads 0 after reset.
  assign wr_addr     = wr_fetch_q ? FetchEnAddr : BootAddrAddr;
  assign wr_word     = wr_fetch_q ? 32'd1 : boot_addr_q;
  assign aw_valid_o  = aw_valid_q;
  assign w_valid_o   = w_valid_q;
  assign aw_addr_o   = aw_valid_q ? wr_addr : '0;
  assign w_data_o    = w_valid_q ? {wr_word, wr_word} : '0;
  assign w_strb_o    = w_valid_q ? (wr_addr[2] ? 8'hF0 : 8'h0F) : '0;
  assign ar_addr_o   = ar_valid_o ? CoreStatusAddr : '0;
  assign busy_o      = busy;
  assign done_o      = done_q;
  assign error_o     = error_q;
  assign err_code_o  = err_code_q;
  assign exit_code_o = exit_code_q;

endmodule
